// File: rtl/sd_bd_sched.sv
`default_nettype none
// ============================================================================
// Module   : sd_bd_sched
// Purpose  : Buffer-descriptor scheduler for the SD host controller.
//            Arbitrates round-robin between the TX (host-to-card) and RX
//            (card-to-host) sd_bd descriptor buffers. Pops one two-word
//            descriptor through the granted slave read port, launches one
//            transfer, waits for completion, error or watchdog timeout, and
//            then frees the descriptor with a one-cycle a_cmp pulse.
//
// Ports    : clk, rst                - clock, synchronous active-low reset
//            en                      - scheduler enable, sampled in IDLE only
//            tx_bd_cnt, rx_bd_cnt    - pending descriptor counts
//            tx_dat_s, rx_dat_s      - sd_bd read data (one cycle after re_s)
//            tx_re_s, rx_re_s        - sd_bd read strobes
//            tx_a_cmp, rx_a_cmp      - descriptor-complete pulses
//            xfer_start              - one-cycle transfer launch pulse
//            xfer_dir                - 1 = TX, 0 = RX
//            xfer_sys_addr           - descriptor word 0
//            xfer_card_addr          - descriptor word 1
//            xfer_done, xfer_err     - transfer master completion / error
//            err_clr                 - clears sticky error status
//            busy                    - high in every state except IDLE
//            err_flag, err_to,
//            err_src                 - sticky error status, timeout flag,
//                                      source buffer (1 = TX)
//
// Revision : 1.0 - initial release
// ============================================================================
module sd_bd_sched #(
    parameter int MEM_W = 32,
    parameter int CNT_W = 5,
    parameter int TO_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] tx_bd_cnt,
    input  logic [CNT_W-1:0] rx_bd_cnt,
    input  logic [MEM_W-1:0] tx_dat_s,
    input  logic [MEM_W-1:0] rx_dat_s,
    output logic             tx_re_s,
    output logic             rx_re_s,
    output logic             tx_a_cmp,
    output logic             rx_a_cmp,
    output logic             xfer_start,
    output logic             xfer_dir,
    output logic [MEM_W-1:0] xfer_sys_addr,
    output logic [MEM_W-1:0] xfer_card_addr,
    input  logic             xfer_done,
    input  logic             xfer_err,
    input  logic             err_clr,
    output logic             busy,
    output logic             err_flag,
    output logic             err_to,
    output logic             err_src
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RD0   = 3'd1;
    localparam logic [2:0] c_ST_RD1   = 3'd2;
    localparam logic [2:0] c_ST_CAP   = 3'd3;
    localparam logic [2:0] c_ST_START = 3'd4;
    localparam logic [2:0] c_ST_WAIT  = 3'd5;
    localparam logic [2:0] c_ST_CMP   = 3'd6;
    localparam logic [2:0] c_ST_GAP   = 3'd7;

    // The watchdog is cleared in START and counts once per WAIT cycle. When it
    // holds all-ones-minus-one, the current WAIT cycle is the one in which it
    // reaches all-ones, so the timeout is taken then (2^TO_W-1 WAIT cycles).
    localparam logic [TO_W-1:0] c_WD_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] c_WD_MAX  = {TO_W{1'b1}};
    localparam logic [TO_W-1:0] c_WD_PRE  = c_WD_MAX - c_WD_ONE;
    localparam logic [TO_W-1:0] c_WD_ZERO = {TO_W{1'b0}};

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic             r_prefer_tx;   // 1: TX wins when both buffers pend
    logic             r_dir;
    logic [MEM_W-1:0] r_sys_addr;
    logic [MEM_W-1:0] r_card_addr;
    logic [TO_W-1:0]  r_wd;
    logic             r_err_flag;
    logic             r_err_to;
    logic             r_err_src;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [2:0]       w_state_nxt;
    logic             w_req_tx;
    logic             w_req_rx;
    logic             w_grant_tx;
    logic             w_grant;
    logic             w_fail;
    logic             w_fail_to;
    logic [MEM_W-1:0] w_dat_sel;

    assign w_req_tx = |tx_bd_cnt;
    assign w_req_rx = |rx_bd_cnt;

    // A lone requester is always granted; with both pending the pointer
    // picks the buffer that was not served last.
    assign w_grant_tx = w_req_tx & (~w_req_rx | r_prefer_tx);

    // Read data from whichever buffer owns the current descriptor.
    assign w_dat_sel = r_dir ? tx_dat_s : rx_dat_s;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_fail      = 1'b0;
        w_fail_to   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (en && (w_req_tx || w_req_rx)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = c_ST_RD0;
                end
            end
            c_ST_RD0:   w_state_nxt = c_ST_RD1;
            c_ST_RD1:   w_state_nxt = c_ST_CAP;
            c_ST_CAP:   w_state_nxt = c_ST_START;
            c_ST_START: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: begin
                // Error outranks a simultaneous done; done outranks timeout.
                if (xfer_err) begin
                    w_fail      = 1'b1;
                    w_state_nxt = c_ST_CMP;
                end else if (xfer_done) begin
                    w_state_nxt = c_ST_CMP;
                end else if (r_wd == c_WD_PRE) begin
                    w_fail      = 1'b1;
                    w_fail_to   = 1'b1;
                    w_state_nxt = c_ST_CMP;
                end
            end
            c_ST_CMP:   w_state_nxt = c_ST_GAP;
            // One dead cycle lets the sd_bd counts settle after a_cmp.
            c_ST_GAP:   w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Grant direction and round-robin pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dir       <= 1'b0;
            r_prefer_tx <= 1'b1;
        end else if (w_grant) begin
            r_dir       <= w_grant_tx;
            r_prefer_tx <= ~w_grant_tx;
        end
    end

    // ------------------------------------------------------------------------
    // Descriptor capture: word 0 arrives during RD1, word 1 during CAP.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sys_addr  <= {MEM_W{1'b0}};
            r_card_addr <= {MEM_W{1'b0}};
        end else begin
            if (r_state == c_ST_RD1) begin
                r_sys_addr <= w_dat_sel;
            end
            if (r_state == c_ST_CAP) begin
                r_card_addr <= w_dat_sel;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transfer watchdog
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wd <= c_WD_ZERO;
        end else if (r_state == c_ST_START) begin
            r_wd <= c_WD_ZERO;
        end else if (r_state == c_ST_WAIT) begin
            r_wd <= r_wd + c_WD_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error status; recording a new error beats a same-cycle clear.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_flag <= 1'b0;
            r_err_to   <= 1'b0;
            r_err_src  <= 1'b0;
        end else if (w_fail) begin
            r_err_flag <= 1'b1;
            r_err_to   <= w_fail_to;
            r_err_src  <= r_dir;
        end else if (err_clr) begin
            r_err_flag <= 1'b0;
            r_err_to   <= 1'b0;
            r_err_src  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Moore outputs decoded from the registered state only
    // ------------------------------------------------------------------------
    logic w_rd_phase;
    logic w_cmp_phase;

    assign w_rd_phase  = (r_state == c_ST_RD0) || (r_state == c_ST_RD1);
    assign w_cmp_phase = (r_state == c_ST_CMP);

    assign tx_re_s        = w_rd_phase  &  r_dir;
    assign rx_re_s        = w_rd_phase  & ~r_dir;
    assign tx_a_cmp       = w_cmp_phase &  r_dir;
    assign rx_a_cmp       = w_cmp_phase & ~r_dir;
    assign xfer_start     = (r_state == c_ST_START);
    assign xfer_dir       = r_dir;
    assign xfer_sys_addr  = r_sys_addr;
    assign xfer_card_addr = r_card_addr;
    assign busy           = (r_state != c_ST_IDLE);
    assign err_flag       = r_err_flag;
    assign err_to         = r_err_to;
    assign err_src        = r_err_src;

endmodule
`default_nettype wire

// File: tb/tb_sd_bd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_bd_sched
// Purpose  : Self-checking bench for sd_bd_sched. A descriptor-level model
//            tracks the cycle offset since each grant and derives every
//            output from it; directed scenarios add literal expectations,
//            followed by a randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_bd_sched;

    localparam int MEM_W = 32;
    localparam int CNT_W = 5;
    localparam int TO_W  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [CNT_W-1:0] tx_bd_cnt = '0;
    logic [CNT_W-1:0] rx_bd_cnt = '0;
    logic [MEM_W-1:0] tx_dat_s = '0;
    logic [MEM_W-1:0] rx_dat_s = '0;
    logic             tx_re_s, rx_re_s, tx_a_cmp, rx_a_cmp;
    logic             xfer_start, xfer_dir;
    logic [MEM_W-1:0] xfer_sys_addr, xfer_card_addr;
    logic             xfer_done = 1'b0;
    logic             xfer_err = 1'b0;
    logic             err_clr = 1'b0;
    logic             busy, err_flag, err_to, err_src;

    always #5 clk = ~clk;

    sd_bd_sched #(.MEM_W(MEM_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .tx_bd_cnt(tx_bd_cnt), .rx_bd_cnt(rx_bd_cnt),
        .tx_dat_s(tx_dat_s), .rx_dat_s(rx_dat_s),
        .tx_re_s(tx_re_s), .rx_re_s(rx_re_s),
        .tx_a_cmp(tx_a_cmp), .rx_a_cmp(rx_a_cmp),
        .xfer_start(xfer_start), .xfer_dir(xfer_dir),
        .xfer_sys_addr(xfer_sys_addr), .xfer_card_addr(xfer_card_addr),
        .xfer_done(xfer_done), .xfer_err(xfer_err), .err_clr(err_clr),
        .busy(busy), .err_flag(err_flag), .err_to(err_to), .err_src(err_src)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // sd_bd read-port emulation: data appears the cycle after a read strobe.
    // Queued words are returned first, otherwise random data.
    // ------------------------------------------------------------------------
    logic [MEM_W-1:0] tx_q[$];
    logic [MEM_W-1:0] rx_q[$];

    always @(posedge clk) begin
        logic tre, rre;
        tre = tx_re_s;
        rre = rx_re_s;
        #1;
        if (tre && tx_q.size() > 0) tx_dat_s = tx_q.pop_front();
        else                        tx_dat_s = $urandom;
        if (rre && rx_q.size() > 0) rx_dat_s = rx_q.pop_front();
        else                        rx_dat_s = $urandom;
    end

    // ------------------------------------------------------------------------
    // Reference model. m_off counts cycles since a grant (0 = idle):
    // reads at 1,2; word0 at 2, word1 at 3; launch at 4; waiting from 5;
    // completion pulse at m_cmp, then one idle gap cycle.
    // ------------------------------------------------------------------------
    int               m_off = 0;
    int               m_cmp = 0;
    bit               m_dir = 0;
    bit               m_prefer_tx = 1;
    bit               m_err = 0, m_to = 0, m_src = 0;
    logic [MEM_W-1:0] m_sys = '0, m_card = '0;
    bit               started = 0;

    always @(posedge clk) begin
        bit set_err, set_to;
        started = 1;
        set_err = 0;
        set_to  = 0;
        if (!rst) begin
            m_off = 0; m_cmp = 0; m_dir = 0; m_prefer_tx = 1;
            m_err = 0; m_to = 0; m_src = 0; m_sys = '0; m_card = '0;
        end else begin
            if (m_off == 0) begin
                if (en && (tx_bd_cnt != 0 || rx_bd_cnt != 0)) begin
                    if (tx_bd_cnt != 0 && rx_bd_cnt != 0) m_dir = m_prefer_tx;
                    else                                  m_dir = (tx_bd_cnt != 0);
                    m_prefer_tx = !m_dir;
                    m_off = 1;
                    m_cmp = 0;
                end
            end else begin
                if (m_off == 2) m_sys  = m_dir ? tx_dat_s : rx_dat_s;
                if (m_off == 3) m_card = m_dir ? tx_dat_s : rx_dat_s;
                if (m_off >= 5 && m_cmp == 0) begin
                    if (xfer_err) begin
                        set_err = 1; m_cmp = m_off + 1;
                    end else if (xfer_done) begin
                        m_cmp = m_off + 1;
                    end else if (m_off - 4 == 2**TO_W - 1) begin
                        set_err = 1; set_to = 1; m_cmp = m_off + 1;
                    end
                end
                if (m_cmp != 0 && m_off == m_cmp + 1) begin
                    m_off = 0;
                    m_cmp = 0;
                end else begin
                    m_off++;
                end
            end
            if (set_err) begin
                m_err = 1; m_to = set_to; m_src = m_dir;
            end else if (err_clr) begin
                m_err = 0; m_to = 0; m_src = 0;
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        bit rd, cp;
        if (started) begin
            rd = (m_off == 1 || m_off == 2);
            cp = (m_cmp != 0 && m_off == m_cmp);
            chk("tx_re_s",        tx_re_s,        rd && m_dir);
            chk("rx_re_s",        rx_re_s,        rd && !m_dir);
            chk("tx_a_cmp",       tx_a_cmp,       cp && m_dir);
            chk("rx_a_cmp",       rx_a_cmp,       cp && !m_dir);
            chk("xfer_start",     xfer_start,     m_off == 4);
            chk("busy",           busy,           m_off != 0);
            chk("xfer_dir",       xfer_dir,       m_dir);
            chk("xfer_sys_addr",  xfer_sys_addr,  m_sys);
            chk("xfer_card_addr", xfer_card_addr, m_card);
            chk("err_flag",       err_flag,       m_err);
            chk("err_to",         err_to,         m_to);
            chk("err_src",        err_src,        m_src);
            chk("re_exclusive",   tx_re_s & rx_re_s, 1'b0);
        end
    end

    // ------------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (xfer_start) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL wait_start: got no xfer_start expected one within 60 cycles");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL wait_idle: got busy expected idle within 60 cycles");
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int n;
        int nre;
        logic [3:0] order;

        repeat (3) step();
        chk("reset_busy", busy, 1'b0);
        chk("reset_sys",  xfer_sys_addr, 32'h0);
        chk("reset_flag", err_flag, 1'b0);
        rst = 1'b1;
        step();

        // Single TX descriptor, done on the third WAIT cycle.
        tx_q.push_back(32'h1000_0000);
        tx_q.push_back(32'h0000_0200);
        en = 1'b1;
        tx_bd_cnt = 5'd1;
        wait_start();
        tx_bd_cnt = 5'd0;
        repeat (3) step();
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        chk("tx_cmp_pulse", tx_a_cmp, 1'b1);
        chk("tx_sys_addr",  xfer_sys_addr,  32'h1000_0000);
        chk("tx_card_addr", xfer_card_addr, 32'h0000_0200);
        chk("tx_dir",       xfer_dir, 1'b1);
        chk("tx_no_err",    err_flag, 1'b0);
        step();
        chk("gap_busy",    busy, 1'b1);
        chk("gap_no_cmp",  tx_a_cmp, 1'b0);
        step();
        chk("idle_busy",   busy, 1'b0);

        // RX descriptor with simultaneous done and error.
        rx_bd_cnt = 5'd1;
        wait_start();
        rx_bd_cnt = 5'd0;
        step();
        xfer_done = 1'b1;
        xfer_err  = 1'b1;
        step();
        xfer_done = 1'b0;
        xfer_err  = 1'b0;
        chk("prio_cmp",  rx_a_cmp, 1'b1);
        chk("prio_flag", err_flag, 1'b1);
        chk("prio_to",   err_to,   1'b0);
        chk("prio_src",  err_src,  1'b0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_flag", err_flag, 1'b0);
        wait_idle();

        // Round robin with both buffers holding two descriptors.
        tx_bd_cnt = 5'd2;
        rx_bd_cnt = 5'd2;
        for (int i = 0; i < 4; i++) begin
            wait_start();
            order[3-i] = xfer_dir;
            if (i == 3) begin
                tx_bd_cnt = 5'd0;
                rx_bd_cnt = 5'd0;
            end
            step();
            xfer_done = 1'b1;
            step();
            xfer_done = 1'b0;
        end
        chk("rr_order", order, 4'b1010);
        wait_idle();

        // Watchdog timeout on a TX descriptor.
        tx_bd_cnt = 5'd1;
        wait_start();
        tx_bd_cnt = 5'd0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (tx_a_cmp) break;
        end
        chk("to_cycles", n, 16);
        chk("to_flag", err_flag, 1'b1);
        chk("to_to",   err_to,   1'b1);
        chk("to_src",  err_src,  1'b1);
        step();
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        step();
        chk("to_late_done", err_to, 1'b1);
        chk("to_idle", busy, 1'b0);

        // Enable dropped while a descriptor is in flight.
        tx_bd_cnt = 5'd1;
        rx_bd_cnt = 5'd1;
        wait_start();
        en = 1'b0;
        step();
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        chk("en_cmp", tx_a_cmp | rx_a_cmp, 1'b1);
        nre = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            nre += int'(tx_re_s) + int'(rx_re_s);
        end
        chk("en_no_reads", nre, 0);
        en = 1'b1;
        wait_start();
        tx_bd_cnt = 5'd0;
        rx_bd_cnt = 5'd0;
        step();
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        wait_idle();

        // Reset while waiting for the transfer.
        tx_bd_cnt = 5'd1;
        wait_start();
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_sys",  xfer_sys_addr, 32'h0);
        chk("rst_cmp",  tx_a_cmp | rx_a_cmp, 1'b0);
        rst = 1'b1;
        step();
        chk("rst_re1", tx_re_s, 1'b1);
        step();
        chk("rst_re2", tx_re_s, 1'b1);
        step();
        chk("rst_re3", tx_re_s, 1'b0);
        wait_start();
        tx_bd_cnt = 5'd0;
        step();
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        wait_idle();

        // Randomized run.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) == 0) tx_bd_cnt = CNT_W'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) rx_bd_cnt = CNT_W'($urandom_range(0, 3));
            en        = ($urandom_range(0, 19) != 0);
            xfer_done = ($urandom_range(0, 5) == 0);
            xfer_err  = ($urandom_range(0, 19) == 0);
            err_clr   = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 599) != 0);
            step();
        end

        rst = 1'b1;
        en = 1'b0;
        xfer_done = 1'b0;
        xfer_err = 1'b0;
        err_clr = 1'b0;
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_bd_sched.md
Name: sd_bd_sched

Overview:
Buffer-descriptor scheduler for the SD host controller. It sits between the two sd_bd descriptor buffers (TX = host-to-card, RX = card-to-host) and the data/command transfer master. When enabled, it arbitrates round-robin between buffers with pending descriptors and pops one two-word descriptor through the slave read port. It then launches one transfer, waits for completion or timeout, and frees the descriptor with a_cmp.

Parameters:
MEM_W, 32, width of one descriptor word (sd_bd slave data width)
CNT_W, 5, width of the pending-descriptor count from each sd_bd
TO_W, 16, width of the transfer watchdog counter; timeout fires at count 2^TO_W-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset (0 = reset)
en  in  1  scheduler enable; sampled only in IDLE
tx_bd_cnt  in  CNT_W  pending descriptors in TX sd_bd
rx_bd_cnt  in  CNT_W  pending descriptors in RX sd_bd
tx_dat_s  in  MEM_W  TX sd_bd slave read data, valid the cycle after tx_re_s
rx_dat_s  in  MEM_W  RX sd_bd slave read data, valid the cycle after rx_re_s
tx_re_s  out  1  TX sd_bd read strobe
rx_re_s  out  1  RX sd_bd read strobe
tx_a_cmp  out  1  TX descriptor-complete pulse
rx_a_cmp  out  1  RX descriptor-complete pulse
xfer_start  out  1  one-cycle transfer launch pulse
xfer_dir  out  1  1 = TX (write card), 0 = RX; held from launch until CMP
xfer_sys_addr  out  MEM_W  descriptor word 0, held from capture until next capture
xfer_card_addr  out  MEM_W  descriptor word 1, held from capture until next capture
xfer_done  in  1  transfer master completion pulse
xfer_err  in  1  transfer master error pulse
err_clr  in  1  clears sticky error status
busy  out  1  1 in every state except IDLE
err_flag  out  1  sticky: a transfer ended in error or timeout
err_to  out  1  valid with err_flag: 1 = timeout, 0 = xfer_err
err_src  out  1  valid with err_flag: 1 = TX, 0 = RX

Behaviour:
- Reset (rst=0 at posedge): state IDLE. All outputs 0, including addresses, err status and watchdog. Round-robin pointer set to favour TX first. Reset mid-transfer aborts without a_cmp.
- All strobes are Moore outputs of the registered state; no combinational input-to-output paths.
- States: IDLE, RD0, RD1, CAP, START, WAIT, CMP, GAP.
- IDLE: requires en=1 and at least one count nonzero.
  - Grant rule: if only one buffer is pending, grant it. If both are pending, grant the buffer not served last.
  - Record grant as xfer_dir, update the pointer, go to RD0.
  - Latency: the first re_s appears one cycle after IDLE sees a request.
- RD0: granted re_s=1. Go to RD1.
- RD1: granted re_s=1. Capture granted dat_s into xfer_sys_addr. Go to CAP.
- CAP: re_s=0. Capture dat_s into xfer_card_addr. Go to START.
- START: xfer_start=1 for one cycle. Clear the watchdog. Go to WAIT.
- WAIT: the watchdog increments each cycle.
  - xfer_err=1 → error with err_to=0. If xfer_done is simultaneous, error wins.
  - Else xfer_done=1 → success.
  - Else watchdog reaches 2^TO_W-1 → error with err_to=1.
  - Late xfer_done/xfer_err after timeout are ignored outside WAIT.
  - Each exit goes to CMP.
- Error recording: sets err_flag=1, latches err_to, and sets err_src = xfer_dir. A later error overwrites err_to/err_src.
- CMP: granted a_cmp=1 for exactly one cycle, on both success and error. Go to GAP.
- GAP: one idle cycle so sd_bd counts can update before re-arbitration. Go to IDLE.
- en=0 mid-operation: the current descriptor runs to completion; no new grant.
- Error clear: err_clr=1 clears err_flag/err_to/err_src next cycle. If an error is recorded in the same cycle, set wins.
- Strobe exclusivity: exactly two re_s pulses and one a_cmp pulse per descriptor. tx_* and rx_* strobes never assert together.
- Minimum descriptor period: 8 cycles with xfer_done returned on the first WAIT cycle.

Test Plan:
- Reset: drive rst=0 for 2 cycles mid-WAIT → all outputs 0 next cycle, no a_cmp, state IDLE; then tx_bd_cnt=1 → tx_re_s high at cycles +1,+2.
- Single TX descriptor: tx_dat_s=0x1000_0000 then 0x0000_0200, xfer_done 3 cycles after start → xfer_sys_addr=0x10000000, xfer_card_addr=0x200, xfer_dir=1, one tx_a_cmp, busy falls after GAP.
- Round robin: tx_bd_cnt=2, rx_bd_cnt=2 held → grant order TX,RX,TX,RX; rx_re_s/tx_re_s never overlap.
- Error priority: xfer_done and xfer_err in same cycle → err_flag=1, err_to=0, err_src matches grant, a_cmp still pulsed once; err_clr → err_flag=0.
- Timeout: TO_W=4, no xfer_done → after 15 WAIT cycles err_to=1, a_cmp pulsed; later xfer_done ignored.
- Enable gating: drop en during WAIT with counts nonzero → current BD completes with a_cmp, no further re_s until en=1.
